regfile_param: RTL and testbench

//  Parametrised general-purpose register file for the TISC datapath.

---
 rtl/regfile_param_if.sv | 40 ++++
 rtl/regfile_param.sv | 113 +++++++++++
 tb/tb_regfile_param.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write, read, scoreboard and clear signals.
// The master drives requests and addresses; the register file answers as slave.
interface regfile_param_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr1;
    logic [WIDTH-1:0] rdata1;
    logic [AW-1:0]    raddr2;
    logic [WIDTH-1:0] rdata2;
    logic             mark_en;
    logic [AW-1:0]    mark_addr;
    logic             pend1;
    logic             pend2;
    logic             clr_req;
    logic             clr_busy;

    modport master (
        output we, waddr, wdata,
        output raddr1, raddr2,
        output mark_en, mark_addr,
        output clr_req,
        input  rdata1, rdata2,
        input  pend1, pend2,
        input  clr_busy
    );

    modport slave (
        input  we, waddr, wdata,
        input  raddr1, raddr2,
        input  mark_en, mark_addr,
        input  clr_req,
        output rdata1, rdata2,
        output pend1, pend2,
        output clr_busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: 1 write, 2 async reads, optional bypass,
// per-register pending bits and a one-entry-per-cycle bulk clear engine.
module regfile_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    regfile_param_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             busy;
    logic             wr_ok;
    logic             mk_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    function automatic logic usable(input logic [AW-1:0] a);
        return in_range(a) && !(ZERO_REG && a == '0);
    endfunction

    assign busy = (state == CLEAR);

    // Gating with rst keeps the bypass from leaking data while in reset.
    assign wr_ok = !rst && bus.we && !busy && usable(bus.waddr);
    assign mk_ok = !rst && bus.mark_en && !busy
                   && usable(bus.mark_addr);

    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0] a
    );
        logic [WIDTH-1:0] d;
        d = '0;
        if (usable(a))
            d = regs[a];
        if (BYPASS && wr_ok && bus.waddr == a)
            d = bus.wdata;
        return d;
    endfunction

    function automatic logic pend_port(input logic [AW-1:0] a);
        logic p;
        p = 1'b0;
        if (in_range(a))
            p = pending[a];
        return p;
    endfunction

    always_comb begin
        bus.rdata1   = read_port(bus.raddr1);
        bus.rdata2   = read_port(bus.raddr2);
        bus.pend1    = pend_port(bus.raddr1);
        bus.pend2    = pend_port(bus.raddr2);
        bus.clr_busy = busy;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.clr_req) state_nxt = CLEAR;
            CLEAR: if (idx == LAST) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR && idx != LAST)
                idx <= idx + 1'b1;
            else
                idx <= '0;
        end
    end

    // Mark is applied after write so a same-cycle mark wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pending <= '0;
        end else if (busy) begin
            regs[idx]    <= '0;
            pending[idx] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[bus.waddr]    <= bus.wdata;
                pending[bus.waddr] <= 1'b0;
            end
            if (mk_ok)
                pending[bus.mark_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (WIDTH=8, DEPTH=8,
// ZERO_REG=1, BYPASS=1) using immediate assertions.
module tb_regfile_param;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    regfile_param_if #(.WIDTH(8), .AW(3)) bus ();

    regfile_param #(
        .WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] val [8];
        int busy_cycles;
        n_chk  = 0;
        n_fail = 0;
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.mark_en   = 1'b0;
        bus.mark_addr = '0;
        bus.clr_req   = 1'b0;
        for (int k = 0; k < 8; k++)
            val[k] = (k == 0) ? 8'h00 : 8'(k * 8'h11);

        // 1: reset state on every address
        tick();
        for (int a = 0; a < 8; a++) begin
            bus.raddr1 = 3'(a);
            bus.raddr2 = 3'(7 - a);
            #1;
            chk($sformatf("rst_rd1_%0d", a), 32'(bus.rdata1), 0);
            chk($sformatf("rst_rd2_%0d", a), 32'(bus.rdata2), 0);
            chk($sformatf("rst_p1_%0d", a), 32'(bus.pend1), 0);
            chk($sformatf("rst_p2_%0d", a), 32'(bus.pend2), 0);
        end
        chk("rst_busy", 32'(bus.clr_busy), 0);
        tick();
        rst = 1'b0;

        // 2: bypass then stored value
        bus.we = 1'b1; bus.waddr = 3; bus.wdata = 8'hA5;
        bus.raddr1 = 3;
        #1;
        chk("byp_same_cycle", 32'(bus.rdata1), 32'hA5);
        tick();
        bus.we = 1'b0;
        #1;
        chk("byp_next_cycle", 32'(bus.rdata1), 32'hA5);
        chk("byp_pend", 32'(bus.pend1), 0);

        // 3: zero register
        bus.we = 1'b1; bus.waddr = 0; bus.wdata = 8'hFF;
        bus.raddr1 = 0;
        #1;
        chk("zero_byp", 32'(bus.rdata1), 0);
        tick();
        bus.we = 1'b0;
        bus.mark_en = 1'b1; bus.mark_addr = 0;
        #1;
        chk("zero_rd", 32'(bus.rdata1), 0);
        tick();
        bus.mark_en = 1'b0;
        #1;
        chk("zero_pend", 32'(bus.pend1), 0);

        // 4: scoreboard on reg 5
        bus.raddr2 = 5;
        bus.mark_en = 1'b1; bus.mark_addr = 5;
        tick();
        bus.mark_en = 1'b0;
        #1;
        chk("pend_c1", 32'(bus.pend2), 1);
        tick();
        chk("pend_c2", 32'(bus.pend2), 1);
        bus.we = 1'b1; bus.waddr = 5; bus.wdata = 8'h5C;
        tick();
        bus.we = 1'b0;
        #1;
        chk("pend_wr_clr", 32'(bus.pend2), 0);
        chk("pend_wr_data", 32'(bus.rdata2), 32'h5C);
        bus.we = 1'b1; bus.wdata = 8'h77;
        bus.mark_en = 1'b1; bus.mark_addr = 5;
        tick();
        bus.we = 1'b0; bus.mark_en = 1'b0;
        #1;
        chk("pend_mark_wins", 32'(bus.pend2), 1);
        chk("pend_mark_data", 32'(bus.rdata2), 32'h77);

        // 5: bulk clear
        for (int k = 1; k < 8; k++) begin
            bus.we = 1'b1; bus.waddr = 3'(k); bus.wdata = val[k];
            tick();
        end
        bus.we = 1'b0;
        bus.raddr1 = 6;
        #1;
        chk("load_r6", 32'(bus.rdata1), 32'h66);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            bus.we      = (c >= 1 && c <= 3);
            bus.waddr   = 7;
            bus.wdata   = 8'hEE;
            bus.mark_en = (c == 2);
            bus.mark_addr = 6;
            bus.raddr1  = 3'(c);
            bus.raddr2  = (c == 0) ? 3'd0 : 3'(c - 1);
            #1;
            if (bus.clr_busy) busy_cycles++;
            chk($sformatf("clr_keep_%0d", c),
                32'(bus.rdata1), 32'(val[c]));
            chk($sformatf("clr_gone_%0d", c),
                32'(bus.rdata2), 0);
            @(posedge clk);
            #1;
        end
        bus.we = 1'b0; bus.mark_en = 1'b0;
        chk("clr_busy_cnt", 32'(busy_cycles), 8);
        chk("clr_busy_end", 32'(bus.clr_busy), 0);
        bus.raddr1 = 7; bus.raddr2 = 6;
        #1;
        chk("clr_we_drop", 32'(bus.rdata1), 0);
        chk("clr_mark_drop", 32'(bus.pend2), 0);
        chk("clr_r6", 32'(bus.rdata2), 0);

        // 6: async reset mid-clear
        for (int k = 1; k < 4; k++) begin
            bus.we = 1'b1; bus.waddr = 3'(k); bus.wdata = val[k];
            tick();
        end
        bus.we = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        tick();
        bus.raddr1 = 3; bus.raddr2 = 2;
        #1;
        chk("mid_busy", 32'(bus.clr_busy), 1);
        chk("mid_r3", 32'(bus.rdata1), 32'h33);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.clr_busy), 0);
        chk("arst_r3", 32'(bus.rdata1), 0);
        chk("arst_r2", 32'(bus.rdata2), 0);
        tick();
        rst = 1'b0;
        bus.we = 1'b1; bus.waddr = 4; bus.wdata = 8'h3C;
        bus.raddr1 = 4;
        tick();
        bus.we = 1'b0;
        #1;
        chk("post_rst_wr", 32'(bus.rdata1), 32'h3C);
        chk("post_rst_busy", 32'(bus.clr_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
